// File: rtl/mem_test_sequencer.sv
// rtl/mem_test_sequencer.sv - burst descriptor sequencer for one memory test run
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   start_i                      single-cycle start request (honoured in IDLE only)
//   test_mode_i, addr_mode_i     test ordering and address generation mode
//   base_addr_i, rnd_seed_i      fixed/start address, LFSR seed
//   trans_cnt_i                  number of address points in the run
//   start_off_i, end_off_i,
//   words_cnt_i, data_mode_i,
//   data_ptrn_i                  per-burst fields, copied to every descriptor
//   trans_valid_o/trans_ready_i  descriptor handshake to the transaction driver
//   trans_*_o                    current descriptor
//   busy_o, done_o, cfg_err_o    run status
module mem_test_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_B_W = 16,
    parameter int BURST_W  = 11,
    parameter int CNT_W    = 32,
    localparam int OFF_W   = $clog2(DATA_B_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           test_mode_i,
    input  logic [2:0]           addr_mode_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [31:0]          rnd_seed_i,
    input  logic [CNT_W-1:0]     trans_cnt_i,
    input  logic [OFF_W-1:0]     start_off_i,
    input  logic [OFF_W-1:0]     end_off_i,
    input  logic [BURST_W-2:0]   words_cnt_i,
    input  logic                 data_mode_i,
    input  logic [7:0]           data_ptrn_i,
    output logic                 trans_valid_o,
    input  logic                 trans_ready_i,
    output logic [ADDR_W-1:0]    trans_addr_o,
    output logic                 trans_type_o,
    output logic [OFF_W-1:0]     trans_start_off_o,
    output logic [OFF_W-1:0]     trans_end_off_o,
    output logic [BURST_W-2:0]   trans_words_o,
    output logic                 trans_data_mode_o,
    output logic [7:0]           trans_data_ptrn_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cfg_err_o
);

    // Number of bit positions the walking 1/0 pattern visits.
    localparam int RUN_N = ADDR_W - OFF_W;
    localparam int POS_W = (RUN_N > 1) ? $clog2(RUN_N) : 1;

    localparam logic [1:0] TM_READ  = 2'b01;
    localparam logic [1:0] TM_WAC   = 2'b11;

    localparam logic [2:0] AM_FIX   = 3'b000;
    localparam logic [2:0] AM_RND   = 3'b001;
    localparam logic [2:0] AM_RUN_0 = 3'b010;
    localparam logic [2:0] AM_RUN_1 = 3'b011;
    localparam logic [2:0] AM_INC   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        tm_q;
    logic [2:0]        am_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  rem_q;       // address points left, including the current one
    logic [POS_W-1:0]  pos_q;       // walking-bit position of the current point
    logic [ADDR_W-1:0] inc_q;       // incrementing address of the current point
    logic [31:0]       lfsr_q;      // LFSR value of the current point
    logic              rd_phase_q;  // read half of a write/read pair

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        // Galois form of x^32+x^22+x^2+x+1
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic [2:0]        am,
        input logic [ADDR_W-1:0] base,
        input logic [POS_W-1:0]  pos,
        input logic [ADDR_W-1:0] inc,
        input logic [31:0]       lfsr
    );
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] onehot;
        onehot = ADDR_W'(1) << (OFF_W + int'(pos));
        case (am)
            AM_RND:   a = ADDR_W'(lfsr);
            AM_RUN_0: a = ~onehot;
            AM_RUN_1: a = onehot;
            AM_INC:   a = inc;
            default:  a = base;
        endcase
        a[OFF_W-1:0] = '0;
        return a;
    endfunction

    logic              start_acc;
    logic              cfg_bad;
    logic              run_empty;
    logic              hs;
    logic              last_desc;
    logic [31:0]       seed_ld;
    logic [POS_W-1:0]  pos_nx;
    logic [ADDR_W-1:0] inc_nx;
    logic [31:0]       lfsr_nx;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign cfg_bad   = (test_mode_i == 2'b00) || (addr_mode_i > AM_INC);
    assign run_empty = (trans_cnt_i == '0);
    assign hs        = trans_valid_o && trans_ready_i;
    // Last point, and for write/read pairs only once the read has gone out.
    assign last_desc = (rem_q == CNT_W'(1)) && ((tm_q != TM_WAC) || rd_phase_q);
    assign seed_ld   = (rnd_seed_i == 32'd0) ? 32'd1 : rnd_seed_i;
    assign pos_nx    = (pos_q == POS_W'(RUN_N - 1)) ? '0 : pos_q + POS_W'(1);
    assign inc_nx    = inc_q + ADDR_W'(DATA_B_W);
    assign lfsr_nx   = lfsr_step(lfsr_q);

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_FINISH);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (cfg_bad || run_empty) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hs && last_desc) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tm_q              <= '0;
            am_q              <= '0;
            base_q            <= '0;
            rem_q             <= '0;
            pos_q             <= '0;
            inc_q             <= '0;
            lfsr_q            <= 32'd1;
            rd_phase_q        <= 1'b0;
            cfg_err_o         <= 1'b0;
            trans_valid_o     <= 1'b0;
            trans_addr_o      <= '0;
            trans_type_o      <= 1'b0;
            trans_start_off_o <= '0;
            trans_end_off_o   <= '0;
            trans_words_o     <= '0;
            trans_data_mode_o <= 1'b0;
            trans_data_ptrn_o <= '0;
        end else if (start_acc) begin
            tm_q              <= test_mode_i;
            am_q              <= addr_mode_i;
            base_q            <= base_addr_i;
            rem_q             <= trans_cnt_i;
            pos_q             <= '0;
            inc_q             <= base_addr_i;
            lfsr_q            <= seed_ld;
            rd_phase_q        <= 1'b0;
            cfg_err_o         <= cfg_bad;
            trans_valid_o     <= !cfg_bad && !run_empty;
            trans_addr_o      <= addr_of(addr_mode_i, base_addr_i, '0, base_addr_i, seed_ld);
            trans_type_o      <= (test_mode_i != TM_READ);
            trans_start_off_o <= start_off_i;
            trans_end_off_o   <= end_off_i;
            trans_words_o     <= words_cnt_i;
            trans_data_mode_o <= data_mode_i;
            trans_data_ptrn_o <= data_ptrn_i;
        end else if (state_q == S_ISSUE && hs) begin
            if (last_desc) begin
                trans_valid_o <= 1'b0;
            end else if (tm_q == TM_WAC && !rd_phase_q) begin
                // Read back the address just written; the point does not advance.
                rd_phase_q   <= 1'b1;
                trans_type_o <= 1'b0;
            end else begin
                rd_phase_q   <= 1'b0;
                rem_q        <= rem_q - CNT_W'(1);
                pos_q        <= pos_nx;
                inc_q        <= inc_nx;
                lfsr_q       <= lfsr_nx;
                trans_addr_o <= addr_of(am_q, base_q, pos_nx, inc_nx, lfsr_nx);
                trans_type_o <= (tm_q != TM_READ);
            end
        end
    end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// tb/tb_mem_test_sequencer.sv - self-checking bench for mem_test_sequencer
module tb_mem_test_sequencer;

    localparam int ADDR_W   = 32;
    localparam int DATA_B_W = 16;
    localparam int BURST_W  = 11;
    localparam int CNT_W    = 32;
    localparam int OFF_W    = 4;
    localparam int LIMIT    = 4000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          test_mode = '0;
    logic [2:0]          addr_mode = '0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [31:0]         rnd_seed = '0;
    logic [CNT_W-1:0]    trans_cnt = '0;
    logic [OFF_W-1:0]    start_off = '0;
    logic [OFF_W-1:0]    end_off = '0;
    logic [BURST_W-2:0]  words_cnt = '0;
    logic                data_mode = 1'b0;
    logic [7:0]          data_ptrn = '0;
    logic                trans_ready = 1'b0;
    logic                trans_valid;
    logic [ADDR_W-1:0]   trans_addr;
    logic                trans_type;
    logic [OFF_W-1:0]    trans_start_off;
    logic [OFF_W-1:0]    trans_end_off;
    logic [BURST_W-2:0]  trans_words;
    logic                trans_data_mode;
    logic [7:0]          trans_data_ptrn;
    logic                busy;
    logic                done;
    logic                cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic        exp_type_q[$];

    mem_test_sequencer #(
        .ADDR_W(ADDR_W), .DATA_B_W(DATA_B_W), .BURST_W(BURST_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .test_mode_i(test_mode), .addr_mode_i(addr_mode),
        .base_addr_i(base_addr), .rnd_seed_i(rnd_seed), .trans_cnt_i(trans_cnt),
        .start_off_i(start_off), .end_off_i(end_off), .words_cnt_i(words_cnt),
        .data_mode_i(data_mode), .data_ptrn_i(data_ptrn),
        .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
        .trans_addr_o(trans_addr), .trans_type_o(trans_type),
        .trans_start_off_o(trans_start_off), .trans_end_off_o(trans_end_off),
        .trans_words_o(trans_words), .trans_data_mode_o(trans_data_mode),
        .trans_data_ptrn_o(trans_data_ptrn),
        .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Expected descriptor list straight from the address rules.
    task automatic build_model(input logic [1:0] tm, input logic [2:0] am,
                               input logic [31:0] base, input logic [31:0] seed,
                               input logic [31:0] cnt);
        logic [31:0] lfsr, a;
        exp_addr_q.delete();
        exp_type_q.delete();
        if (tm == 2'b00 || am > 3'd4 || cnt == 0) return;
        lfsr = (seed == 0) ? 32'd1 : seed;
        for (longint k = 0; k < longint'(cnt); k++) begin
            case (am)
                3'd0:    a = base;
                3'd1:    a = lfsr;
                3'd2:    a = ~(32'd1 << (4 + k % 28));
                3'd3:    a = 32'd1 << (4 + k % 28);
                default: a = base + 32'(k) * 32'd16;
            endcase
            a = a & 32'hFFFF_FFF0;
            if (tm == 2'b11) begin
                exp_addr_q.push_back(a); exp_type_q.push_back(1'b1);
                exp_addr_q.push_back(a); exp_type_q.push_back(1'b0);
            end else begin
                exp_addr_q.push_back(a); exp_type_q.push_back(tm == 2'b10);
            end
            lfsr = lfsr_next(lfsr);
        end
    endtask

    task automatic scramble_cfg();
        test_mode = 2'($urandom); addr_mode = 3'($urandom);
        base_addr = $urandom; rnd_seed = $urandom; trans_cnt = $urandom;
        start_off = 4'($urandom); end_off = 4'($urandom);
        words_cnt = 10'($urandom); data_mode = 1'($urandom); data_ptrn = 8'($urandom);
    endtask

    // ready_mode: 0 always ready, 1 toggling 1/0, 2 random
    task automatic run_cfg(input string name, input logic [1:0] tm, input logic [2:0] am,
                           input logic [31:0] base, input logic [31:0] seed,
                           input logic [31:0] cnt, input int ready_mode, input bit poke_start);
        logic [26:0] exp_fields, fields, held_fields;
        logic [31:0] held_addr;
        logic        held_type, exp_err, r, stalled;
        int          cyc;
        build_model(tm, am, base, seed, cnt);
        exp_err = (tm == 2'b00) || (am > 3'd4);
        @(negedge clk);
        test_mode = tm; addr_mode = am; base_addr = base; rnd_seed = seed; trans_cnt = cnt;
        start_off = 4'($urandom); end_off = 4'($urandom); words_cnt = 10'($urandom);
        data_mode = 1'($urandom); data_ptrn = 8'($urandom);
        exp_fields = {start_off, end_off, words_cnt, data_mode, data_ptrn};
        start = 1'b1; trans_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        n_checks++;
        if (cfg_err !== exp_err) begin
            n_fail++; $display("FAIL %s cfg_err: got %b want %b", name, cfg_err, exp_err);
        end
        cyc = 0; stalled = 1'b0; held_addr = '0; held_type = 1'b0; held_fields = '0;
        while (exp_addr_q.size() > 0 && cyc < LIMIT) begin
            fields = {trans_start_off, trans_end_off, trans_words, trans_data_mode, trans_data_ptrn};
            n_checks++;
            if (trans_valid !== 1'b1) begin
                n_fail++; $display("FAIL %s valid_cyc%0d: got %b want 1", name, cyc, trans_valid);
            end
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++; $display("FAIL %s early_done_cyc%0d: got %b want 0", name, cyc, done);
            end
            if (stalled) begin
                n_checks++;
                if ({trans_addr, trans_type, fields} !== {held_addr, held_type, held_fields}) begin
                    n_fail++;
                    $display("FAIL %s stall_hold_cyc%0d: got %h/%b want %h/%b",
                             name, cyc, trans_addr, trans_type, held_addr, held_type);
                end
            end
            n_checks++;
            if (trans_addr !== exp_addr_q[0]) begin
                n_fail++; $display("FAIL %s addr_cyc%0d: got %h want %h", name, cyc, trans_addr, exp_addr_q[0]);
            end
            n_checks++;
            if (trans_type !== exp_type_q[0]) begin
                n_fail++; $display("FAIL %s type_cyc%0d: got %b want %b", name, cyc, trans_type, exp_type_q[0]);
            end
            n_checks++;
            if (fields !== exp_fields) begin
                n_fail++; $display("FAIL %s fields_cyc%0d: got %h want %h", name, cyc, fields, exp_fields);
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom);
            endcase
            trans_ready = r;
            start = poke_start && (cyc == 3);
            if (start) scramble_cfg();
            if (r && trans_valid === 1'b1) begin
                void'(exp_addr_q.pop_front());
                void'(exp_type_q.pop_front());
            end
            stalled = !r;
            held_addr = trans_addr; held_type = trans_type; held_fields = fields;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        trans_ready = 1'b0;
        if (cyc >= LIMIT) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got %0d left want 0", name, exp_addr_q.size());
        end
        n_checks++;
        if ({trans_valid, done, busy} !== 3'b011) begin
            n_fail++; $display("FAIL %s end_state: got v/d/b=%b%b%b want 011", name, trans_valid, done, busy);
        end
        n_checks++;
        if (cfg_err !== exp_err) begin
            n_fail++; $display("FAIL %s cfg_err_sticky: got %b want %b", name, cfg_err, exp_err);
        end
        @(negedge clk);
        n_checks++;
        if ({trans_valid, done, busy} !== 3'b000) begin
            n_fail++; $display("FAIL %s idle_state: got v/d/b=%b%b%b want 000", name, trans_valid, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({trans_valid, busy, done, cfg_err, trans_addr, trans_type} !== 36'd0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b b=%b d=%b e=%b a=%h want all 0",
                               trans_valid, busy, done, cfg_err, trans_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wac_inc();
        run_cfg("wac_inc", 2'b11, 3'd4, 32'h100, 32'h0, 32'd3, 0, 1'b0);
    endtask

    task automatic test_read_run1();
        run_cfg("read_run1", 2'b01, 3'd3, $urandom, $urandom, 32'd30, 0, 1'b0);
    endtask

    task automatic test_write_fix_toggle();
        run_cfg("write_fix", 2'b10, 3'd0, 32'h1234_5678, 32'h0, 32'd9, 1, 1'b0);
    endtask

    task automatic test_rnd_seed0();
        run_cfg("rnd_seed0", 2'b11, 3'd1, 32'h0, 32'h0, 32'd12, 2, 1'b0);
    endtask

    task automatic test_run0();
        run_cfg("run0", 2'b10, 3'd2, 32'h0, 32'h0, 32'd31, 2, 1'b0);
    endtask

    task automatic test_empty_and_errors();
        run_cfg("empty_run", 2'b11, 3'd4, 32'h40, 32'h0, 32'd0, 0, 1'b0);
        run_cfg("bad_test_mode", 2'b00, 3'd4, 32'h40, 32'h0, 32'd5, 0, 1'b0);
        run_cfg("bad_addr_mode", 2'b01, 3'd6, 32'h40, 32'h0, 32'd5, 0, 1'b0);
        run_cfg("clear_err", 2'b01, 3'd4, 32'h40, 32'h0, 32'd2, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_cfg("start_busy", 2'b11, 3'd4, 32'h2000, 32'h0, 32'd6, 2, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_cfg("random", 2'($urandom_range(1, 3)), 3'($urandom_range(0, 4)),
                    $urandom, $urandom, 32'($urandom_range(1, 40)), 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        test_mode = 2'b10; addr_mode = 3'd4; base_addr = 32'h0; trans_cnt = 32'd50;
        start = 1'b1; trans_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; trans_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (trans_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_run_valid: got %b want 1", trans_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({trans_valid, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset: got v/b/d=%b%b%b want 000", trans_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0; trans_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({trans_valid, busy, done} !== 3'b000) begin
                n_fail++; $display("FAIL post_reset_cyc%0d: got v/b/d=%b%b%b want 000", i, trans_valid, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wac_inc();
        test_read_run1();
        test_write_fix_toggle();
        test_rnd_seed0();
        test_run0();
        test_empty_and_errors();
        test_start_ignored();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_test_sequencer.md
Name: mem_test_sequencer

Overview:
- Sequences one memory test run for the checker.
- On a start pulse, samples the test configuration and generates a stream of burst transaction descriptors: address, type, offsets, word count and data pattern.
- The stream follows the selected test mode and address mode.
- Each descriptor is handed to the Avalon-MM transaction driver over a valid/ready handshake; read descriptors are also consumed by the compare path.

Parameters:
ADDR_W, 32, byte-address width of generated addresses (MEM_ADDR_W + log2(MEM_DATA_W/8))
DATA_B_W, 16, bytes per AMM word; the address low bits log2(DATA_B_W) are always zero
BURST_W, 11, AMM burst width; the word count field is BURST_W-1 bits
CNT_W, 32, width of the address-point counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  single-cycle start request
test_mode_i  in  2  01 READ_ONLY, 10 WRITE_ONLY, 11 WRITE_AND_CHECK, 00 invalid
addr_mode_i  in  3  000 FIX, 001 RND, 010 RUN_0, 011 RUN_1, 100 INC, others invalid
base_addr_i  in  ADDR_W  fixed/start address
rnd_seed_i  in  32  LFSR seed
trans_cnt_i  in  CNT_W  number of address points
start_off_i  in  log2(DATA_B_W)  first-word byte offset
end_off_i  in  log2(DATA_B_W)  last-word byte offset
words_cnt_i  in  BURST_W-1  words per burst
data_mode_i  in  1  0 FIX_DATA, 1 RND_DATA
data_ptrn_i  in  8  data pattern byte
trans_valid_o  out  1  descriptor valid
trans_ready_i  in  1  driver accepts descriptor
trans_addr_o  out  ADDR_W  burst address, word aligned
trans_type_o  out  1  1 write, 0 read
trans_start_off_o / trans_end_off_o / trans_words_o / trans_data_mode_o / trans_data_ptrn_o  out  as inputs  registered copies of the config
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at end of run
cfg_err_o  out  1  sticky until next start; invalid mode seen

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; LFSR 1.
- States: IDLE -> ISSUE -> FINISH -> IDLE.
- Start acceptance:
  - start_i is honoured only in IDLE. In busy states it is ignored.
  - On accepted start, all config inputs are registered.
  - The config inputs are don't-care afterwards.
- Invalid config or empty run:
  - If test_mode is 00 or addr_mode is invalid: cfg_err_o=1, then FINISH.
  - If trans_cnt_i=0: FINISH without error.
- Normal start:
  - State goes to ISSUE and the first descriptor is loaded.
  - busy_o=1 and trans_valid_o=1 in cycle N+1 after start in cycle N.
- ISSUE handshake:
  - All descriptor outputs are held stable while valid&&!ready.
  - On valid&&ready, the next descriptor is loaded in the same edge. valid stays high, so there is no bubble.
- Test mode ordering:
  - WRITE_AND_CHECK: for each address point, a write descriptor then a read descriptor to the same address. The address advances after the read.
  - READ_ONLY and WRITE_ONLY: one descriptor of the fixed type per point.
- Address generation (point index k, 0-based; wrap mod 2^ADDR_W; low log2(DATA_B_W) bits forced 0):
  - FIX: base_addr.
  - INC: base_addr + k*DATA_B_W.
  - RUN_1: one-hot bit at position log2(DATA_B_W) + (k mod (ADDR_W-log2(DATA_B_W))).
  - RUN_0: bitwise inverse of RUN_1, low bits still 0.
  - RND: LFSR value, with the low bits masked.
- LFSR:
  - 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1.
  - Loaded with the seed on start; a seed of 0 is loaded as 1.
  - Steps once per address point; the first point uses the seed.
- End of run:
  - After the handshake of the last descriptor (trans_cnt points, x2 for WRITE_AND_CHECK), valid drops next cycle and state goes to FINISH.
  - FINISH: done_o=1 for one cycle, busy_o=0 from the following cycle, return to IDLE.
- Counters: the point counter is CNT_W wide. trans_cnt = 2^CNT_W-1 completes without overflow.
- Reset mid-run: all outputs clear immediately (asynchronous). No done_o pulse.

Test Plan:
- WRITE_AND_CHECK, INC, base=0x100, cnt=3, ready always 1 -> descriptors W100,R100,W110,R110,W120,R120 on 6 consecutive cycles; done_o pulses 1 cycle after the last.
- READ_ONLY, RUN_1, cnt=30, ADDR_W=32 -> addresses 0x10,0x20,…,0x8000_0000, then wrap to 0x10 (28-position cycle); all trans_type_o=0.
- WRITE_ONLY, FIX, base=0x1234_5678, ready toggling 1/0 -> every address 0x1234_5670; outputs stable during ready=0; exactly cnt handshakes.
- RND, seed=0 -> first address = 1 masked = 0x0; second address = LFSR step of 1, masked, matching the reference model; cnt=0 -> no valid, done_o one cycle after start.
- test_mode=00 -> cfg_err_o=1, done_o pulse, no valid. start_i during busy ignored. rst_i asserted mid-ISSUE -> valid/busy=0 immediately, no done_o pulse.
